// File: rtl/titan_mem_stage.sv
// Memory-access stage: drives the data port through a request/ready FSM,
// stalls while busy, extends load data. Optional bus timeout: TITAN_MEM_TIMEOUT_EN.
module titan_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [5:0]  mem_mem_flags,
  input  logic        kill,
  input  logic        wb_stall,
  output logic [31:0] dport_address,
  output logic [31:0] dport_data_o,
  output logic [3:0]  dport_sel,
  output logic        dport_wr,
  output logic        dport_enable,
  input  logic [31:0] dport_data_i,
  input  logic        dport_ready,
  input  logic        dport_error,
  output logic        mem_stall_req,
  output logic [31:0] mem_load_data,
  output logic        mem_load_misaligned,
  output logic        mem_store_misaligned,
  output logic        mem_load_fault,
  output logic        mem_store_fault,
  output logic [31:0] mem_fault_address
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t state_q, state_d;

  logic [31:0] addr_q, data_q, load_q;
  logic [3:0]  sel_q;
  logic [1:0]  size_q;
  logic        wr_q, uns_q, killed_q, fault_q;

  logic        req_rd, req_wr, pending, misaligned, start;
  logic [1:0]  req_size;
  logic [3:0]  sel_in;
  logic [31:0] wdata_in, shifted, load_ext;
  logic        timeout_hit, bus_err, bus_done;
  logic        unused_ok;

  assign req_rd     = mem_mem_flags[0];
  assign req_wr     = mem_mem_flags[1];
  assign req_size   = mem_mem_flags[3:2];
  assign pending    = (req_rd | req_wr) & ~kill;
  assign misaligned = ((req_size == 2'b01) & mem_address[0]) |
                      (req_size[1] & (mem_address[1:0] != 2'b00));
  assign start      = pending & ~misaligned;
  assign unused_ok  = ^{mem_mem_flags[5], 8'(TIMEOUT_CYCLES)};

  always_comb begin
    sel_in   = 4'b1111;
    wdata_in = mem_store_data;
    case (req_size)
      2'b00: begin
        sel_in   = 4'b0001 << mem_address[1:0];
        wdata_in = {4{mem_store_data[7:0]}};
      end
      2'b01: begin
        sel_in   = 4'b0011 << mem_address[1:0];
        wdata_in = {2{mem_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = dport_data_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      2'b00: load_ext = uns_q ? {24'b0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_ext = uns_q ? {16'b0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

`ifdef TITAN_MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_BUSY) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  assign timeout_hit = (state_q == S_BUSY) && !dport_ready && !dport_error &&
                       (tmo_cnt_q == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign bus_err  = dport_error | timeout_hit;
  assign bus_done = dport_ready | bus_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // A kill seen at any point of BUSY drops the result once the bus lets go.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (bus_done) state_d = (killed_q | kill) ? S_IDLE : S_DONE;
      S_DONE:  if (kill | ~wb_stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      sel_q    <= '0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      killed_q <= 1'b0;
      fault_q  <= 1'b0;
      load_q   <= '0;
    end else if (state_q == S_IDLE && start) begin
      addr_q   <= mem_address;
      data_q   <= wdata_in;
      sel_q    <= sel_in;
      wr_q     <= req_wr;
      size_q   <= req_size;
      uns_q    <= mem_mem_flags[4];
      killed_q <= 1'b0;
      fault_q  <= 1'b0;
      load_q   <= '0;
    end else if (state_q == S_BUSY) begin
      if (kill) killed_q <= 1'b1;
      if (bus_err)                   fault_q <= 1'b1;
      else if (dport_ready && !wr_q) load_q  <= load_ext;
    end
  end

  always_comb begin
    dport_address        = {addr_q[31:2], 2'b00};
    dport_data_o         = data_q;
    dport_sel            = 4'b0000;
    dport_wr             = 1'b0;
    dport_enable         = 1'b0;
    mem_stall_req        = 1'b0;
    mem_load_data        = '0;
    mem_load_misaligned  = 1'b0;
    mem_store_misaligned = 1'b0;
    mem_load_fault       = 1'b0;
    mem_store_fault      = 1'b0;
    mem_fault_address    = '0;
    case (state_q)
      S_IDLE: begin
        mem_stall_req        = start;
        mem_load_misaligned  = pending & misaligned & ~req_wr;
        mem_store_misaligned = pending & misaligned & req_wr;
        if (pending & misaligned) mem_fault_address = mem_address;
      end
      S_BUSY: begin
        dport_enable  = 1'b1;
        dport_sel     = sel_q;
        dport_wr      = wr_q;
        mem_stall_req = 1'b1;
      end
      S_DONE: begin
        mem_load_data   = load_q;
        mem_load_fault  = fault_q & ~wr_q;
        mem_store_fault = fault_q & wr_q;
        if (fault_q) mem_fault_address = addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_titan_mem_stage.sv
// Randomized self-checking bench for titan_mem_stage against a lane-level model.
module tb_titan_mem_stage;

`ifdef TITAN_MEM_TIMEOUT_EN
  localparam int TMO = 4;
  localparam int MAX_WAIT = 2;
`else
  localparam int TMO = 255;
  localparam int MAX_WAIT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address, mem_store_data, dport_data_i;
  logic [5:0]  mem_mem_flags;
  logic        kill, wb_stall, dport_ready, dport_error;
  logic [31:0] dport_address, dport_data_o, mem_load_data, mem_fault_address;
  logic [3:0]  dport_sel;
  logic        dport_wr, dport_enable, mem_stall_req;
  logic        mem_load_misaligned, mem_store_misaligned, mem_load_fault, mem_store_fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  titan_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_store_data(mem_store_data),
    .mem_mem_flags(mem_mem_flags), .kill(kill), .wb_stall(wb_stall),
    .dport_address(dport_address), .dport_data_o(dport_data_o),
    .dport_sel(dport_sel), .dport_wr(dport_wr), .dport_enable(dport_enable),
    .dport_data_i(dport_data_i), .dport_ready(dport_ready), .dport_error(dport_error),
    .mem_stall_req(mem_stall_req), .mem_load_data(mem_load_data),
    .mem_load_misaligned(mem_load_misaligned), .mem_store_misaligned(mem_store_misaligned),
    .mem_load_fault(mem_load_fault), .mem_store_fault(mem_store_fault),
    .mem_fault_address(mem_fault_address)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_sel(input logic [31:0] a, input int nb);
    int off = int'(a[1:0]);
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input int nb);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                             input int nb, input bit uns);
    longint val, range;
    val = longint'(rd) >> (8 * int'(a[1:0]));
    if (nb == 4) return rd;
    range = longint'(1) << (8 * nb);
    val = val % range;
    if (!uns && val >= range / 2) val = val - range;
    return val[31:0];
  endfunction

  function automatic bit is_misaligned(input logic [31:0] a, input int nb);
    return (nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0);
  endfunction

  task automatic idle_inputs();
    mem_mem_flags = '0;
    kill = 1'b0;
    wb_stall = 1'b0;
    dport_ready = 1'b0;
    dport_error = 1'b0;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  task automatic run_access(input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [5:0] flags, input int waits, input bit err,
                            input int wbs, input logic [31:0] rdata);
    bit is_wr = flags[1];
    int nb = nbytes_of(flags[3:2]);
    logic [31:0] exp_ld = err ? 32'h0 : model_load(rdata, addr, nb, flags[4]);
    mem_address = addr;
    mem_store_data = sdata;
    mem_mem_flags = flags;
    #1;
    check_eq("c0_stall", 32'(mem_stall_req), 32'd1);
    check_eq("c0_enable", 32'(dport_enable), 32'd0);
    @(posedge clk); @(negedge clk);
    for (int c = 0; c <= waits; c++) begin
      dport_ready  = (c == waits) && !err;
      dport_error  = (c == waits) && err;
      dport_data_i = (c == waits) ? rdata : $urandom;
      #1;
      check_eq("busy_enable", 32'(dport_enable), 32'd1);
      check_eq("busy_stall", 32'(mem_stall_req), 32'd1);
      check_eq("busy_addr", dport_address, {addr[31:2], 2'b00});
      check_eq("busy_sel", 32'(dport_sel), 32'(model_sel(addr, nb)));
      check_eq("busy_wr", 32'(dport_wr), 32'(is_wr));
      if (is_wr) check_eq("busy_wdata", dport_data_o, model_wdata(sdata, nb));
      @(posedge clk); @(negedge clk);
      dport_ready = 1'b0;
      dport_error = 1'b0;
    end
    for (int k = 0; k <= wbs; k++) begin
      wb_stall = (k < wbs);
      #1;
      check_eq("done_stall", 32'(mem_stall_req), 32'd0);
      check_eq("done_enable", 32'(dport_enable), 32'd0);
      if (!is_wr) check_eq("done_load", mem_load_data, exp_ld);
      check_eq("done_lfault", 32'(mem_load_fault), 32'(err && !is_wr));
      check_eq("done_sfault", 32'(mem_store_fault), 32'(err && is_wr));
      if (err) check_eq("done_faddr", mem_fault_address, addr);
      @(posedge clk); @(negedge clk);
    end
    idle_inputs();
    #1;
    check_eq("post_stall", 32'(mem_stall_req), 32'd0);
    check_eq("post_load", mem_load_data, 32'd0);
    check_eq("post_fault", 32'({mem_load_fault, mem_store_fault}), 32'd0);
  endtask

  task automatic run_misaligned(input logic [31:0] addr, input logic [5:0] flags);
    bit is_wr = flags[1];
    mem_address = addr;
    mem_mem_flags = flags;
    #1;
    check_eq("mis_load", 32'(mem_load_misaligned), 32'(!is_wr));
    check_eq("mis_store", 32'(mem_store_misaligned), 32'(is_wr));
    check_eq("mis_faddr", mem_fault_address, addr);
    check_eq("mis_stall", 32'(mem_stall_req), 32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    check_eq("mis_enable", 32'(dport_enable), 32'd0);
    idle_inputs();
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [5:0]  f;
    int nb;
    rst = 1'b0;
    mem_address = '0;
    mem_store_data = '0;
    dport_data_i = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_enable", 32'(dport_enable), 32'd0);
    check_eq("rst_sel_wr", 32'({dport_sel, dport_wr}), 32'd0);
    check_eq("rst_addr", dport_address, 32'd0);
    check_eq("rst_wdata", dport_data_o, 32'd0);
    check_eq("rst_load", mem_load_data, 32'd0);
    check_eq("rst_faults", 32'({mem_load_fault, mem_store_fault,
                                mem_load_misaligned, mem_store_misaligned}), 32'd0);
    check_eq("rst_faddr", mem_fault_address, 32'd0);
    check_eq("rst_stall", 32'(mem_stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_access(32'h100, 32'h0, 6'b001001, 0, 1'b0, 0, 32'h8765_4321);
    run_access(32'h103, 32'h0, 6'b000001, 0, 1'b0, 0, 32'h8012_3456);
    run_access(32'h103, 32'h0, 6'b010001, 1, 1'b0, 1, 32'h8012_3456);
    run_access(32'h202, 32'h0000_1234, 6'b000110, 3, 1'b0, 0, 32'h0);
    run_access(32'h300, 32'hCAFE_F00D, 6'b001010, 0, 1'b1, 2, 32'h0);
    run_access(32'h402, 32'h0, 6'b000111, 0, 1'b0, 0, 32'h0);
    run_misaligned(32'h101, 6'b001001);
    run_misaligned(32'h203, 6'b000110);

    // Kill during BUSY: error completes the bus cycle but is discarded.
    mem_address = 32'h500;
    mem_mem_flags = 6'b001010;
    @(posedge clk); @(negedge clk);
    kill = 1'b1;
    #1;
    check_eq("kill_busy_en", 32'(dport_enable), 32'd1);
    @(posedge clk); @(negedge clk);
    kill = 1'b0;
    mem_mem_flags = '0;
    dport_error = 1'b1;
    #1;
    check_eq("kill_hold_stall", 32'(mem_stall_req), 32'd1);
    @(posedge clk); @(negedge clk);
    dport_error = 1'b0;
    #1;
    check_eq("kill_idle_en", 32'(dport_enable), 32'd0);
    check_eq("kill_sfault", 32'(mem_store_fault), 32'd0);
    check_eq("kill_stall", 32'(mem_stall_req), 32'd0);

    // Kill while DONE is held by wb_stall.
    mem_address = 32'h600;
    mem_mem_flags = 6'b001001;
    @(posedge clk); @(negedge clk);
    dport_ready = 1'b1;
    dport_data_i = 32'h1357_9BDF;
    @(posedge clk); @(negedge clk);
    dport_ready = 1'b0;
    wb_stall = 1'b1;
    #1;
    check_eq("kdone_load", mem_load_data, 32'h1357_9BDF);
    kill = 1'b1;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    #1;
    check_eq("kdone_clear", mem_load_data, 32'd0);

    // Reset during BUSY drops the request immediately.
    mem_address = 32'h700;
    mem_mem_flags = 6'b001001;
    @(posedge clk); @(negedge clk);
    #1;
    check_eq("rbusy_en", 32'(dport_enable), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_eq("rbusy_drop", 32'(dport_enable), 32'd0);
    check_eq("rbusy_sel", 32'(dport_sel), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef TITAN_MEM_TIMEOUT_EN
    mem_address = 32'h800;
    mem_mem_flags = 6'b001001;
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < TMO; c++) begin
      #1;
      check_eq("tmo_busy_en", 32'(dport_enable), 32'd1);
      @(posedge clk); @(negedge clk);
    end
    #1;
    check_eq("tmo_en", 32'(dport_enable), 32'd0);
    check_eq("tmo_lfault", 32'(mem_load_fault), 32'd1);
    idle_inputs();
    @(posedge clk); @(negedge clk);
`endif

    for (int t = 0; t < 40; t++) begin
      f = {1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom_range(1, 3))};
      nb = nbytes_of(f[3:2]);
      a = $urandom;
      if (nb > 1 && $urandom_range(0, 5) == 0) begin
        if (!is_misaligned(a, nb)) a[0] = 1'b1;
        run_misaligned(a, f);
      end else begin
        if (nb == 2) a[0] = 1'b0;
        if (nb == 4) a[1:0] = 2'b00;
        run_access(a, $urandom, f, $urandom_range(0, MAX_WAIT),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/titan_mem_stage.md
# titan_mem_stage

Memory-access stage of the Titan pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its address, store data and memory flags. It drives the data-port bus through a small request/ready state machine, stalls the pipeline while an access is outstanding, and produces aligned, sign- or zero-extended load data. It also flags misaligned accesses and bus access faults to the exception unit.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: bus cycles without `dport_ready`/`dport_error` before a timeout fault is raised. Only used when `TITAN_MEM_TIMEOUT_EN` is defined; valid range is 1–255.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_address`  in  32  effective address (the EX/MEM result).
- `mem_store_data`  in  32  store data, right-aligned.
- `mem_mem_flags`  in  6  flag bits:
  - [0] read
  - [1] write
  - [3:2] size: 00 byte, 01 half, 10 word, 11 illegal (treated as word)
  - [4] unsigned load
  - [5] reserved, ignored
- `kill`  in  1  the instruction in MEM is being flushed.
- `wb_stall`  in  1  downstream stall; holds the completed result.
- `dport_address`  out  32  word-aligned bus address.
- `dport_data_o`  out  32  lane-shifted write data.
- `dport_sel`  out  4  byte enables.
- `dport_wr`  out  1  1 = write.
- `dport_enable`  out  1  request valid.
- `dport_data_i`  in  32  read data.
- `dport_ready`  in  1  transaction complete.
- `dport_error`  in  1  transaction failed; terminates the transaction like `dport_ready`.
- `mem_stall_req`  out  1  the pipeline must hold IF through MEM.
- `mem_load_data`  out  32  extended load result.
- `mem_load_misaligned`  out  1  misaligned load.
- `mem_store_misaligned`  out  1  misaligned store.
- `mem_load_fault`  out  1  access fault on a load.
- `mem_store_fault`  out  1  access fault on a store.
- `mem_fault_address`  out  32  the byte address that faulted.

## Operation
- An access is pending when `read | write` is set and `kill` is low. If both `read` and `write` are set, the access is treated as a write.
- Misalignment check:
  - half: `addr[0] != 0` is misaligned.
  - word: `addr[1:0] != 0` is misaligned.
  - A misaligned access issues no bus request. The corresponding misaligned flag and `mem_fault_address` are combinational in the same cycle, and `mem_stall_req` stays low.
- `dport_sel` values:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- `dport_data_o`: store data replicated across lanes (byte ×4, half ×2, word as is).
- Load extraction: shift `dport_data_i` right by `8*addr[1:0]`, then sign-extend from bit 7 or 15 unless unsigned is set.
- State machine:
  - IDLE: when an aligned access is pending, latch address, data, sel, wr and size, then go to BUSY.
  - BUSY: `dport_enable` is 1 and the bus outputs are held stable.
    - On `dport_ready`, latch the extracted load data and go to DONE.
    - On `dport_error`, set the fault flag and go to DONE.
  - DONE: stay while `wb_stall` is high; otherwise return to IDLE.
- `mem_stall_req` = (IDLE and aligned access pending) or BUSY.
- `kill` while in BUSY: the bus transaction still completes, because bus requests cannot be aborted. The state then goes straight to IDLE, the result and fault are discarded, and `mem_stall_req` stays high until completion.
- `kill` while in DONE: outputs clear next cycle and the state returns to IDLE.
- `mem_load_data` and the fault flags are valid only in DONE. They read 0 in every other state.

## Timing
- Reset (rst low, asynchronous): state IDLE; `dport_enable`, `dport_wr` and `dport_sel` are 0; the address and data outputs are 0; `mem_load_data`, every fault flag and `mem_fault_address` are 0. Reset mid-transaction drops `dport_enable` immediately.
- Minimum access latency is 3 cycles:
  - cycle 0: access is presented, `mem_stall_req` = 1.
  - cycle 1: BUSY with `dport_enable`; `dport_ready` is sampled in this cycle.
  - cycle 2: DONE, `mem_stall_req` = 0, and the EX/MEM register advances at the end of cycle 2.
- Each wait-state cycle (ready low) adds one cycle of latency.
- `dport_ready` and `dport_error` are ignored outside BUSY.
- A new access can enter IDLE on the cycle after DONE exits. Back-to-back accesses therefore occur every 3 cycles at best.

## Configuration
- `TITAN_MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches `TIMEOUT_CYCLES` without ready or error, the block treats the transaction as `dport_error`: fault flag set, `dport_enable` dropped, state goes to DONE.
- Not defined: no counter is built, and BUSY waits indefinitely.

## Test plan
- Word load at 0x100, ready on the first BUSY cycle, data 0x8765_4321 → `dport_sel` = F, `mem_load_data` = 0x8765_4321 in cycle 2, stall high for cycles 0–1.
- Signed byte load at 0x103 with data 0x80xx_xxxx → `sel` = 4'b1000, `mem_load_data` = 0xFFFF_FF80. The unsigned variant gives 0x0000_0080.
- Half store of 0x1234 at 0x202 → `sel` = 4'b1100, `dport_data_o` = 0x1234_1234, `dport_wr` = 1, 3 wait states → stall for 5 cycles.
- Word load at 0x101 → `mem_load_misaligned` = 1, fault address 0x101, `dport_enable` never asserted.
- Store with `dport_error` → `mem_store_fault` = 1 in DONE. Kill asserted during BUSY → fault discarded and IDLE reached.
- With `TITAN_MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, `dport_ready` held low → load fault raised after 4 BUSY cycles. Asserting `rst` during BUSY drops `dport_enable` asynchronously.
